// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared types, constants and delay clamp for handshake_responder
package handshake_pkg;

    typedef enum logic [3:0] {
        HS_IDLE = 4'd0,
        HS_WAIT = 4'd1,
        HS_ACK  = 4'd2,
        HS_HOLD = 4'd3
    } hs_state_e;

    localparam int HS_MAX_DELAY = 5;

    // Map a raw 3-bit latency request onto the legal range 1..max_d
    function automatic logic [2:0] hs_clamp_delay(input logic [2:0] cfg, input logic [2:0] max_d);
        if (cfg == 3'd0) begin
            return 3'd1;
        end else if (cfg > max_d) begin
            return max_d;
        end else begin
            return cfg;
        end
    endfunction

endpackage

// File: rtl/handshake_responder_sat_counter.sv
// rtl/handshake_responder_sat_counter.sv - event counter with saturate or wrap behaviour
module sat_counter #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // Count increments; a saturating counter sticks at all-ones, a wrapping one rolls over
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc_i && !(SATURATE && (count_q == {WIDTH{1'b1}}))) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/handshake_responder.sv
// rtl/handshake_responder.sv - req/ack responder with programmable latency; stats under HANDSHAKE_RESPONDER_STATS_EN
module handshake_responder
    import handshake_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_DELAY = HS_MAX_DELAY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              data_en,
    input  logic [DATA_W-1:0] data,
    input  logic [2:0]        cfg_delay,
    output logic              ack,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [3:0]        state,
    output logic [7:0]        abort_cnt,
    output logic [15:0]       ack_cnt
);

    localparam logic [2:0] MAX_D = 3'(MAX_DELAY);

    hs_state_e         state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              den_q, den_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [2:0]        eff_delay;
    logic              abort_inc;
    logic              ack_inc;

    // State, countdown and latched request registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HS_IDLE;
            cnt_q      <= 3'd0;
            data_q     <= '0;
            den_q      <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            den_q      <= den_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, one-cycle ACK, HOLD until req falls
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        den_d      = den_q;
        rsp_data_d = rsp_data_q;
        abort_inc  = 1'b0;
        eff_delay  = hs_clamp_delay(cfg_delay, MAX_D);
        case (state_q)
            HS_IDLE: begin
                if (req) begin
                    data_d  = data;
                    den_d   = data_en;
                    cnt_d   = eff_delay - 3'd1;
                    state_d = (eff_delay == 3'd1) ? HS_ACK : HS_WAIT;
                end
            end
            HS_WAIT: begin
                // A dropped req wins even on the cycle that would have entered ACK
                if (!req) begin
                    state_d   = HS_IDLE;
                    abort_inc = 1'b1;
                end else if (cnt_q == 3'd1) begin
                    state_d = HS_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            HS_ACK: begin
                state_d = req ? HS_HOLD : HS_IDLE;
            end
            HS_HOLD: begin
                if (!req) begin
                    state_d = HS_IDLE;
                end
            end
            default: begin
                state_d = HS_IDLE;
            end
        endcase
        // Response payload only changes when a new ACK is about to be presented
        if (state_d == HS_ACK && state_q != HS_ACK) begin
            rsp_data_d = data_d;
        end
    end

    assign ack_inc   = (state_q == HS_ACK);
    assign ack       = ack_inc;
    assign rsp_valid = ack_inc & den_q;
    assign rsp_data  = rsp_data_q;
    assign state     = state_q;

`ifdef HANDSHAKE_RESPONDER_STATS_EN
    sat_counter #(.WIDTH(8), .SATURATE(1'b1)) u_abort_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (abort_inc),
        .count_o(abort_cnt)
    );

    sat_counter #(.WIDTH(16), .SATURATE(1'b0)) u_ack_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (ack_inc),
        .count_o(ack_cnt)
    );
`else
    logic unused_stats;
    assign unused_stats = abort_inc ^ ack_inc;
    assign abort_cnt    = 8'd0;
    assign ack_cnt      = 16'd0;
`endif

endmodule

// File: doc/handshake_responder.md
# handshake_responder

Request/acknowledge responder for the single-clock req/ack handshake used across the SVA test designs. It accepts a held-high `req`, waits a runtime-programmable 1–5 cycle latency, then pulses `ack` together with the data latched at acceptance. This block is the acknowledging end of the interface, so it satisfies `req |-> ##[1:5] ack` by construction. It also reports its FSM state and optional protocol statistics for assertion benches.

## Interface
- `DATA_W`, default 8: width of request/response data.
- `MAX_DELAY`, default 5: upper clamp for `cfg_delay`.
- `clk` in, 1: sole clock; all logic on the rising edge.
- `reset` in, 1: synchronous, active-high reset.
- `req` in, 1: request, held high by the initiator until `ack` is seen.
- `data_en` in, 1: qualifies `data` at request acceptance.
- `data` in, `DATA_W`: request payload.
- `cfg_delay` in, 3: requested ack latency in cycles; sampled at acceptance.
- `ack` out, 1: one-cycle acknowledge pulse.
- `rsp_valid` out, 1: high with `ack` when the accepted request had `data_en`=1.
- `rsp_data` out, `DATA_W`: latched payload; valid while `rsp_valid`.
- `state` out, 4: current FSM encoding.
- `abort_cnt` out, 8: saturating count of requests dropped before `ack`.
- `ack_cnt` out, 16: wrapping count of `ack` pulses.

## Operation
- States, with their `state` encoding:
  - IDLE = 4'd0
  - WAIT = 4'd1
  - ACK = 4'd2
  - HOLD = 4'd3
- Effective delay: `d` = clamp(`cfg_delay`, 1, `MAX_DELAY`). A value of 0 maps to 1; values 6 and 7 map to 5.
- IDLE:
  - With `req`=1, accept: latch `data` and `data_en`, load `cnt` = `d`−1.
  - Go to ACK if `d`=1, else to WAIT.
- WAIT:
  - If `req`=0, the request is aborted: go to IDLE and increment `abort_cnt` (saturating at 255).
  - Else, if `cnt`=1, go to ACK.
  - Else, decrement `cnt`.
- ACK:
  - `ack`=1. `rsp_valid` = latched `data_en`. `ack_cnt`+1.
  - Next state is HOLD if `req`=1, else IDLE.
- HOLD:
  - Wait for `req`=0, then go to IDLE.
  - `req` in HOLD never starts a new request, so an initiator that keeps `req` high gets exactly one `ack`.
- `rsp_data` holds the last latched value outside ACK. It is not cleared.

## Timing
- Reset values: `state`=0, `ack`=0, `rsp_valid`=0, `rsp_data`=0, `cnt`=0, `abort_cnt`=0, `ack_cnt`=0.
- After reset is released, `state`=0 is guaranteed for the first cycle.
- Latency: `req` sampled high in IDLE at edge t gives `ack` high in the cycle after edge t+`d`−1, i.e. exactly `d` cycles after acceptance.
  - With `d`=1, this is `req |=> ack`.
- `ack` is high for exactly one cycle per accepted request.
- The minimum request spacing is 3 cycles:
  - ACK→IDLE needs `req` low in the ACK cycle.
  - A new rise is accepted on the next cycle.
- `cfg_delay` changes after acceptance have no effect on the request in flight.
- If `req` drops in the same cycle that WAIT would move to ACK, the abort wins: no `ack`, and `abort_cnt` increments.
- Reset asserted mid-operation, in any state, gives all outputs at reset values on the next cycle. The in-flight request is discarded and not counted as an abort.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- `HANDSHAKE_RESPONDER_STATS_EN`:
  - Defined: `abort_cnt` and `ack_cnt` are implemented as above.
  - Undefined: both are tied to 0, their registers are removed, and FSM behaviour is unchanged.

## Structure
- Package `handshake_pkg` holds:
  - the state enum `hs_state_e` (4-bit, encodings above);
  - `HS_MAX_DELAY` = 5;
  - the delay clamp function.
- Sub-module `sat_counter` (parameters: width, saturate/wrap select) is used for both statistics counters.

## Test plan
1. Reset, then release: `state`=0 on the first cycle after release, and all outputs are 0.
2. `cfg_delay`=3, `req`=1 held, `data_en`=1, `data`=8'hA5 → `ack`=1 and `rsp_data`=8'hA5 exactly 3 cycles after acceptance. `state` goes 1, 1, 2, then 3 until `req` drops.
3. `cfg_delay`=0 and `cfg_delay`=7 → `ack` arrives at 1 and 5 cycles respectively. `cfg_delay`=0 satisfies `req |=> ack`.
4. `cfg_delay`=4, `req` dropped after 2 cycles → no `ack`, `state` returns to 0, `abort_cnt`=1. Repeat 300 times → `abort_cnt` stays at 255.
5. `req` held high for 10 cycles with `cfg_delay`=1 → a single `ack` pulse, and `ack_cnt`=1.
6. `reset` asserted in WAIT → next cycle `state`=0, no later `ack`, and `abort_cnt` unchanged.
